serial_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `serial_register` transmit channel among `g_requesters` independent 32-bit word sources. Examples of sources are the page-select response, motor-status change events and a heartbeat. The block sits between the requesters and the `data_ib32` input of one `serial_register` instance in the GEFE-side system. It sequences each word through the register's load/busy handshake and guards against a stalled transmitter with a timeout.

---
 rtl/serial_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_serial_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one serial_register transmit channel, with a busy-handshake timeout.
// Optional macro SERIAL_TX_ARB_PRIO0_EN makes requester 0 strict-priority.
module serial_tx_arbiter #(
    parameter int g_requesters  = 4,
    parameter int g_busyTimeout = 1024
) (
    input  logic                                clk_ik,
    input  logic                                rst_irn,
    input  logic [g_requesters-1:0]             req_ib,
    input  logic [g_requesters-1:0][31:0]       data_ib32,
    output logic [g_requesters-1:0]             ack_ob,
    output logic [31:0]                         data_ob32,
    output logic                                load_o,
    input  logic                                busy_i,
    output logic                                active_o,
    output logic [$clog2(g_requesters)-1:0]     grant_ob,
    output logic                                timeout_o,
    input  logic                                clear_i
);
    localparam int W  = $clog2(g_requesters);
    localparam int CW = $clog2(g_busyTimeout);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t                  r_state;
    logic [W-1:0]            r_ptr;
    logic [31:0]             r_data;
    logic                    r_load;
    logic [g_requesters-1:0] r_ack;
    logic                    r_active;
    logic [W-1:0]            r_grant;
    logic                    r_timeout;
    logic [CW-1:0]           r_cnt;

    logic                    w_found;
    logic [W-1:0]            w_winner;
    logic                    w_prio;

    // Search starts just after the last round-robin winner and wraps.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_prio   = 1'b0;
        for (int k = 1; k <= g_requesters; k++) begin
            logic [W-1:0] w_idx;
            w_idx = W'((int'(r_ptr) + k) % g_requesters);
            if (!w_found && req_ib[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
`ifdef SERIAL_TX_ARB_PRIO0_EN
        if (req_ib[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
            w_prio   = 1'b1;
        end
`else
        w_prio = 1'b0;
`endif
    end

    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            r_state   <= S_IDLE;
            r_ptr     <= W'(g_requesters - 1);
            r_data    <= '0;
            r_load    <= 1'b0;
            r_ack     <= '0;
            r_active  <= 1'b0;
            r_grant   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_load <= 1'b0;
            r_ack  <= '0;
            if (clear_i) begin
                r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_data          <= data_ib32[w_winner];
                        r_grant         <= w_winner;
                        if (!w_prio) begin
                            r_ptr <= w_winner;
                        end
                        r_load          <= 1'b1;
                        r_ack[w_winner] <= 1'b1;
                        r_active        <= 1'b1;
                        r_state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        // Counter reaches g_busyTimeout-1 on this edge; set beats clear.
                        if (r_cnt == CW'(g_busyTimeout - 2)) begin
                            r_timeout <= 1'b1;
                            r_active  <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy_i) begin
                        r_active <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack_ob    = r_ack;
    assign data_ob32 = r_data;
    assign load_o    = r_load;
    assign active_o  = r_active;
    assign grant_ob  = r_grant;
    assign timeout_o = r_timeout;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: stimulus pushes expected grants, a monitor checks each load.
module tb_serial_tx_arbiter;
    localparam int N = 4;
    localparam int T = 16;
`ifdef SERIAL_TX_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_ib;
    logic [N-1:0][31:0]  data_ib32;
    logic [N-1:0]        ack_ob;
    logic [31:0]         data_ob32;
    logic                load_o;
    logic                busy_i;
    logic                active_o;
    logic [1:0]          grant_ob;
    logic                timeout_o;
    logic                clear_i;

    serial_tx_arbiter #(.g_requesters(N), .g_busyTimeout(T)) dut (
        .clk_ik(clk), .rst_irn(rst_n), .req_ib(req_ib), .data_ib32(data_ib32),
        .ack_ob(ack_ob), .data_ob32(data_ob32), .load_o(load_o), .busy_i(busy_i),
        .active_o(active_o), .grant_ob(grant_ob), .timeout_o(timeout_o), .clear_i(clear_i)
    );

    typedef struct { int idx; logic [31:0] word; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issued[N] = '{default: 0};
    int acked[N]  = '{default: 0};
    bit busy_en = 1'b1;
    int bd = 2;
    int bl = 3;
    int m_last = N - 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Requesters: level request held while issued words remain unacknowledged.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) if (ack_ob[i]) acked[i]++;
    end

    initial begin
        req_ib = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) req_ib[i] = (issued[i] != acked[i]);
        end
    end

    // Transmitter model: busy rises bd cycles after load, stays high bl cycles.
    initial begin
        int d;
        int l;
        busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (load_o && busy_en && rst_n) begin
                d = bd;
                l = bl;
                repeat (d) @(posedge clk);
                #1 busy_i = 1'b1;
                repeat (l) @(posedge clk);
                #1 busy_i = 1'b0;
            end
        end
    end

    // Monitor: pops one expected grant per load strobe.
    initial begin
        exp_t e;
        logic [N-1:0] ea;
        bit fell_pending;
        logic prev_busy;
        fell_pending = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fell_pending) chk("active_after_busy_fall", {31'd0, active_o}, 32'd0);
                fell_pending = prev_busy && !busy_i;
                if (load_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_load", {31'd0, load_o}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        ea = '0;
                        ea[e.idx] = 1'b1;
                        $display("load grant=%0d data=0x%08h exp_grant=%0d exp_data=0x%08h",
                                 grant_ob, data_ob32, e.idx, e.word);
                        chk("grant", {30'd0, grant_ob}, 32'(e.idx));
                        chk("data", data_ob32, e.word);
                        chk("ack", {28'd0, ack_ob}, {28'd0, ea});
                        chk("load_busy_overlap", {31'd0, busy_i}, 32'd0);
                        chk("active_at_load", {31'd0, active_o}, 32'd1);
                    end
                end
            end else begin
                fell_pending = 1'b0;
            end
            prev_busy = busy_i;
        end
    end

    function automatic bit all_acked();
        for (int i = 0; i < N; i++) if (issued[i] != acked[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: requesters raised together while idle are served once each,
    // in cyclic order after the last round-robin winner (requester 0 first with priority).
    task automatic issue(input logic [N-1:0] mask, input logic [31:0] word, input bit fixed);
        exp_t e;
        int last;
        last = m_last;
        for (int i = 0; i < N; i++) if (mask[i]) data_ib32[i] = fixed ? word : $urandom;
        if (PRIO && mask[0]) begin
            e.idx = 0;
            e.word = data_ib32[0];
            exp_q.push_back(e);
        end
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (mask[idx] && !(PRIO && idx == 0)) begin
                e.idx = idx;
                e.word = data_ib32[idx];
                exp_q.push_back(e);
                last = idx;
            end
        end
        m_last = last;
        for (int i = 0; i < N; i++) if (mask[i]) issued[i]++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !active_o && !busy_i && req_ib == '0 && all_acked())) begin
            tick();
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL %s_idle_wait actual=expired required=idle", tag);
                break;
            end
        end
    endtask

    task automatic wait_load(input string tag);
        int n;
        n = 0;
        while (!load_o) begin
            tick();
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL %s_load_wait actual=expired required=load", tag);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, data_ob32, 32'd0);
        chk({tag, "_load"}, {31'd0, load_o}, 32'd0);
        chk({tag, "_ack"}, {28'd0, ack_ob}, 32'd0);
        chk({tag, "_active"}, {31'd0, active_o}, 32'd0);
        chk({tag, "_grant"}, {30'd0, grant_ob}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int c0;
        int n;
        int fair_seq[8];
        rst_n = 1'b0;
        clear_i = 1'b0;
        data_ib32 = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_active", {31'd0, active_o}, 32'd0);

        // Fairness: all four held for two words each.
        if (PRIO) fair_seq = '{0, 0, 1, 2, 3, 1, 2, 3};
        else      fair_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < N; i++) data_ib32[i] = $urandom;
        for (int j = 0; j < 8; j++) begin
            e.idx = fair_seq[j];
            e.word = data_ib32[fair_seq[j]];
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) issued[i] += 2;
        m_last = 3;
        wait_idle("fairness");

        // Single request with busy 3 cycles after load.
        bd = 3;
        bl = 4;
        issue(4'b0100, 32'hCAFE0002, 1'b1);
        wait_idle("single");

        // Late request from requester 1 during a requester-3 transfer.
        bd = 2;
        bl = 6;
        issue(4'b1000, 32'd0, 1'b0);
        n = 0;
        while (!busy_i && n < 100) begin tick(); n++; end
        chk("late_busy_seen", {31'd0, busy_i}, 32'd1);
        tick();
        issue(4'b0010, 32'd0, 1'b0);
        n = 0;
        while (busy_i && n < 100) begin tick(); n++; end
        tick();
        chk("late_idle_noload", {31'd0, load_o}, 32'd0);
        tick();
        chk("late_first_idle_load", {31'd0, load_o}, 32'd1);
        chk("late_grant", {30'd0, grant_ob}, 32'd1);
        wait_idle("late");

        // Randomized batches.
        for (int b = 0; b < 40; b++) begin
            bd = $urandom_range(1, 4);
            bl = $urandom_range(1, 5);
            issue(4'($urandom_range(1, 15)), 32'd0, 1'b0);
            wait_idle("random");
        end

        // Timeout: busy never rises, request held so it is re-granted.
        busy_en = 1'b0;
        bd = 2;
        bl = 3;
        data_ib32[1] = $urandom;
        e.idx = 1;
        e.word = data_ib32[1];
        exp_q.push_back(e);
        exp_q.push_back(e);
        issued[1] += 2;
        m_last = 1;
        wait_load("timeout");
        c0 = cyc;
        chk("timeout_clear_at_load", {31'd0, timeout_o}, 32'd0);
        n = 0;
        while (!timeout_o && n < 100) begin tick(); n++; end
        chk("timeout_latency", 32'(cyc - c0), 32'd16);
        busy_en = 1'b1;
        wait_idle("timeout");
        chk("timeout_sticky", {31'd0, timeout_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("timeout_cleared", {31'd0, timeout_o}, 32'd0);

        // Clear and timeout in the same cycle: set wins.
        busy_en = 1'b0;
        issue(4'b1000, 32'd0, 1'b0);
        wait_load("collision");
        repeat (15) tick();
        chk("collision_pre", {31'd0, timeout_o}, 32'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("collision_set_wins", {31'd0, timeout_o}, 32'd1);
        busy_en = 1'b1;
        wait_idle("collision");

        // Reset asserted during WAIT_BUSY.
        busy_en = 1'b0;
        issue(4'b0100, 32'd0, 1'b0);
        wait_load("midreset");
        repeat (2) tick();
        chk("midreset_active_before", {31'd0, active_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        m_last = N - 1;
        busy_en = 1'b1;
        tick();
        issue(4'b1111, 32'd0, 1'b0);
        wait_idle("after_reset");

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
